// File: rtl/clock_mode_ctrl_if.sv
// Front-panel bundle between the button/timekeeper side and the clock mode controller.
// The master drives buttons, tick and live time; the slave returns commands, alarm digits and display state.
interface clock_mode_ctrl_if;
   logic       ModePulse;
   logic       IncPulse;
   logic       TickSec;
   logic [3:0] hours2;
   logic [3:0] hours1;
   logic [3:0] mins2;
   logic [3:0] mins1;
   logic       MinInc;
   logic       HourInc;
   logic       HoldSeconds;
   logic [3:0] AlarmH2;
   logic [3:0] AlarmH1;
   logic [3:0] AlarmM2;
   logic [3:0] AlarmM1;
   logic [3:0] DigitBlank;
   logic [2:0] Mode;
   logic       AlarmOn;
   logic       Buzz;

   modport master (
      output ModePulse, IncPulse, TickSec, hours2, hours1, mins2, mins1,
      input  MinInc, HourInc, HoldSeconds, AlarmH2, AlarmH1, AlarmM2, AlarmM1,
             DigitBlank, Mode, AlarmOn, Buzz
   );

   modport slave (
      input  ModePulse, IncPulse, TickSec, hours2, hours1, mins2, mins1,
      output MinInc, HourInc, HoldSeconds, AlarmH2, AlarmH1, AlarmM2, AlarmM1,
             DigitBlank, Mode, AlarmOn, Buzz
   );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Wall-clock front-panel controller: mode sequencing, time/alarm setting commands,
// digit blinking while setting, and alarm match / buzzer sequencing.
module clock_mode_ctrl #(
   parameter int         BLINK_DIV   = 50000000,
   parameter int         RING_SECS   = 30,
   parameter logic [7:0] ALARM_H_RST = 8'h07,
   parameter logic [7:0] ALARM_M_RST = 8'h00
) (
   input logic               CLK100MHZ,
   input logic               Reset,
   clock_mode_ctrl_if.slave  bus
);

   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam int RW = $clog2(RING_SECS) + 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [RW-1:0] RING_LAST  = RW'(RING_SECS - 1);

   typedef enum logic [2:0] {
      RUN    = 3'd0,
      SET_H  = 3'd1,
      SET_M  = 3'd2,
      SET_AH = 3'd3,
      SET_AM = 3'd4
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [BW-1:0] blink_cnt;
   logic [BW-1:0] blink_cnt_n;
   logic          blink_phase;
   logic          blink_phase_n;
   logic [3:0]    blank_n;
   logic [RW-1:0] ring_cnt;
   logic [7:0]    alarm_h;
   logic [7:0]    alarm_m;
   logic          triggered;
   logic          alarm_on;
   logic          buzz;
   logic          hour_inc;
   logic          min_inc;
   logic          hold_seconds;
   logic [3:0]    digit_blank;
   logic          inc_ok;
   logic          live_eq;
   logic          match;

   function automatic logic [7:0] incHour(input logic [7:0] h);
      if (h == 8'h23)
         return 8'h00;
      else if (h[3:0] == 4'd9)
         return {h[7:4] + 4'd1, 4'd0};
      else
         return {h[7:4], h[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] incMin(input logic [7:0] m);
      if (m[3:0] == 4'd9)
         return {(m[7:4] == 4'd5) ? 4'd0 : m[7:4] + 4'd1, 4'd0};
      else
         return {m[7:4], m[3:0] + 4'd1};
   endfunction

   // A mode press always wins over a simultaneous increment press.
   assign inc_ok  = bus.IncPulse && !bus.ModePulse;
   assign live_eq = ({bus.hours2, bus.hours1, bus.mins2, bus.mins1} == {alarm_h, alarm_m});
   assign match   = alarm_on && bus.TickSec && live_eq && !triggered;

   always_comb begin
      next_state = RUN;
      case (state)
         RUN:     next_state = bus.ModePulse ? SET_H  : RUN;
         SET_H:   next_state = bus.ModePulse ? SET_M  : SET_H;
         SET_M:   next_state = bus.ModePulse ? SET_AH : SET_M;
         SET_AH:  next_state = bus.ModePulse ? SET_AM : SET_AH;
         SET_AM:  next_state = bus.ModePulse ? RUN    : SET_AM;
         default: next_state = RUN;
      endcase
   end

   // Blink phase restarts visible on every state change so the user sees digits first.
   always_comb begin
      blink_cnt_n   = blink_cnt + 1'b1;
      blink_phase_n = blink_phase;
      if (next_state != state) begin
         blink_cnt_n   = '0;
         blink_phase_n = 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt_n   = '0;
         blink_phase_n = ~blink_phase;
      end
      blank_n = 4'b0000;
      case (next_state)
         SET_H, SET_AH: blank_n = blink_phase_n ? 4'b1100 : 4'b0000;
         SET_M, SET_AM: blank_n = blink_phase_n ? 4'b0011 : 4'b0000;
         default:       blank_n = 4'b0000;
      endcase
   end

   always_ff @(posedge CLK100MHZ) begin
      if (Reset) begin
         state        <= RUN;
         blink_cnt    <= '0;
         blink_phase  <= 1'b0;
         digit_blank  <= 4'b0000;
         hold_seconds <= 1'b0;
         hour_inc     <= 1'b0;
         min_inc      <= 1'b0;
         alarm_h      <= ALARM_H_RST;
         alarm_m      <= ALARM_M_RST;
         alarm_on     <= 1'b0;
         buzz         <= 1'b0;
         ring_cnt     <= '0;
         triggered    <= 1'b0;
      end else begin
         state        <= next_state;
         blink_cnt    <= blink_cnt_n;
         blink_phase  <= blink_phase_n;
         digit_blank  <= blank_n;
         hold_seconds <= (next_state == SET_H) || (next_state == SET_M);
         hour_inc     <= inc_ok && (state == SET_H);
         min_inc      <= inc_ok && (state == SET_M);

         if (inc_ok && (state == SET_AH))
            alarm_h <= incHour(alarm_h);
         if (inc_ok && (state == SET_AM))
            alarm_m <= incMin(alarm_m);

         if (!live_eq)
            triggered <= 1'b0;

         // Buzzer only lives in RUN; an increment press silences it before it can disarm.
         if (state != RUN || bus.ModePulse) begin
            buzz <= 1'b0;
         end else if (inc_ok) begin
            if (buzz)
               buzz <= 1'b0;
            else
               alarm_on <= ~alarm_on;
         end else if (match) begin
            buzz      <= 1'b1;
            ring_cnt  <= '0;
            triggered <= 1'b1;
         end else if (buzz && bus.TickSec) begin
            if (ring_cnt == RING_LAST)
               buzz <= 1'b0;
            else
               ring_cnt <= ring_cnt + 1'b1;
         end
      end
   end

   assign bus.Mode        = state;
   assign bus.HourInc     = hour_inc;
   assign bus.MinInc      = min_inc;
   assign bus.HoldSeconds = hold_seconds;
   assign bus.DigitBlank  = digit_blank;
   assign bus.AlarmH2     = alarm_h[7:4];
   assign bus.AlarmH1     = alarm_h[3:0];
   assign bus.AlarmM2     = alarm_m[7:4];
   assign bus.AlarmM1     = alarm_m[3:0];
   assign bus.AlarmOn     = alarm_on;
   assign bus.Buzz        = buzz;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl: stimulus queues expected output values tagged with the
// cycle they must appear in; a negedge monitor pops and compares them against the DUT.
module tb_clock_mode_ctrl;

   localparam int F_MODE  = 0;
   localparam int F_HINC  = 1;
   localparam int F_MINC  = 2;
   localparam int F_HOLD  = 3;
   localparam int F_ALARM = 4;
   localparam int F_BLANK = 5;
   localparam int F_AON   = 6;
   localparam int F_BUZZ  = 7;

   typedef struct {
      int          cyc;
      int          sel;
      logic [15:0] val;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   nChecks = 0;
   int   nFails = 0;
   exp_t sb[$];

   clock_mode_ctrl_if bus();

   clock_mode_ctrl #(
      .BLINK_DIV  (4),
      .RING_SECS  (3),
      .ALARM_H_RST(8'h07),
      .ALARM_M_RST(8'h00)
   ) dut (
      .CLK100MHZ(clk),
      .Reset    (reset),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] getField(input int sel);
      case (sel)
         F_MODE:  return {13'd0, bus.Mode};
         F_HINC:  return {15'd0, bus.HourInc};
         F_MINC:  return {15'd0, bus.MinInc};
         F_HOLD:  return {15'd0, bus.HoldSeconds};
         F_ALARM: return {bus.AlarmH2, bus.AlarmH1, bus.AlarmM2, bus.AlarmM1};
         F_BLANK: return {12'd0, bus.DigitBlank};
         F_AON:   return {15'd0, bus.AlarmOn};
         default: return {15'd0, bus.Buzz};
      endcase
   endfunction

   // Monitor: every expectation due at or before this cycle is compared mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      logic [15:0] act;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         act = getField(e.sel);
         nChecks++;
         if (e.cyc != cyc || act !== e.val) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h (due cycle %0d, seen %0d)",
                     e.name, act, e.val, e.cyc, cyc);
         end
      end
   end

   task automatic checkOutput(input int dly, input int sel, input logic [15:0] val, input string name);
      exp_t e;
      e.cyc  = cyc + dly;
      e.sel  = sel;
      e.val  = val;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input bit mp, input bit ip, input bit ts);
      bus.ModePulse = mp;
      bus.IncPulse  = ip;
      bus.TickSec   = ts;
      @(posedge clk);
      #1;
      bus.ModePulse = 1'b0;
      bus.IncPulse  = 1'b0;
      bus.TickSec   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0);
   endtask

   task automatic setLive(input logic [3:0] h2, input logic [3:0] h1, input logic [3:0] m2, input logic [3:0] m1);
      bus.hours2 = h2;
      bus.hours1 = h1;
      bus.mins2  = m2;
      bus.mins1  = m1;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput(0, F_MODE,  16'h0000, {tag, " mode"});
      checkOutput(0, F_HINC,  16'h0000, {tag, " hourinc"});
      checkOutput(0, F_MINC,  16'h0000, {tag, " mininc"});
      checkOutput(0, F_HOLD,  16'h0000, {tag, " hold"});
      checkOutput(0, F_BLANK, 16'h0000, {tag, " blank"});
      checkOutput(0, F_AON,   16'h0000, {tag, " alarmon"});
      checkOutput(0, F_BUZZ,  16'h0000, {tag, " buzz"});
      checkOutput(0, F_ALARM, 16'h0700, {tag, " alarm"});
   endtask

   initial begin
      logic [3:0] blinkSeq [8];
      bus.ModePulse = 1'b0;
      bus.IncPulse  = 1'b0;
      bus.TickSec   = 1'b0;
      setLive(4'd0, 4'd0, 4'd0, 4'd0);

      repeat (2) @(posedge clk);
      #1;
      checkResetState("por");
      reset = 1'b0;

      // Mode walk with hold-seconds only in the time-setting modes.
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1, 0, 0);
         checkOutput(0, F_MODE, 16'(i % 5), "mode step");
         checkOutput(0, F_HOLD, (i == 1 || i == 2) ? 16'h1 : 16'h0, "hold step");
      end

      applyStimulus(1, 0, 0);
      applyStimulus(0, 1, 0);
      checkOutput(0, F_HINC, 16'h1, "hourinc pulse");
      checkOutput(0, F_MINC, 16'h0, "mininc quiet in set_h");
      applyStimulus(0, 0, 0);
      checkOutput(0, F_HINC, 16'h0, "hourinc one cycle");
      applyStimulus(1, 1, 0);
      checkOutput(0, F_MODE, 16'h2, "mode+inc mode");
      checkOutput(0, F_HINC, 16'h0, "mode+inc no hourinc");
      checkOutput(0, F_MINC, 16'h0, "mode+inc no mininc");
      applyStimulus(0, 1, 0);
      checkOutput(0, F_MINC, 16'h1, "mininc pulse");
      checkOutput(0, F_HINC, 16'h0, "hourinc quiet in set_m");
      applyStimulus(0, 0, 0);
      checkOutput(0, F_MINC, 16'h0, "mininc one cycle");

      // Alarm hour walk 07 -> 23 -> 00 -> 07.
      applyStimulus(1, 0, 0);
      for (int i = 1; i <= 24; i++) begin
         applyStimulus(0, 1, 0);
         if (i == 3)  checkOutput(0, F_ALARM, 16'h1000, "alarm hour 09->10");
         if (i == 13) checkOutput(0, F_ALARM, 16'h2000, "alarm hour 19->20");
         if (i == 16) checkOutput(0, F_ALARM, 16'h2300, "alarm hour 23");
         if (i == 17) checkOutput(0, F_ALARM, 16'h0000, "alarm hour 23->00");
         if (i == 24) checkOutput(0, F_ALARM, 16'h0700, "alarm hour back 07");
      end

      // Alarm minute walk 00 -> 59 -> 00.
      applyStimulus(1, 0, 0);
      for (int i = 1; i <= 60; i++) begin
         applyStimulus(0, 1, 0);
         if (i == 10) checkOutput(0, F_ALARM, 16'h0710, "alarm min 09->10");
         if (i == 59) checkOutput(0, F_ALARM, 16'h0759, "alarm min 59");
         if (i == 60) checkOutput(0, F_ALARM, 16'h0700, "alarm min 59->00");
      end

      // Blink in SET_M, then restart visible on entry to SET_AH.
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      checkOutput(0, F_MODE, 16'h2, "enter set_m");
      for (int k = 0; k < 6; k++)
         checkOutput(k, F_BLANK, (k < 4) ? 16'h0 : 16'h3, "blink set_m");
      idle(5);
      applyStimulus(1, 0, 0);
      blinkSeq = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hC, 4'hC, 4'hC, 4'hC};
      for (int k = 0; k < 8; k++)
         checkOutput(k, F_BLANK, {12'd0, blinkSeq[k]}, "blink set_ah");
      idle(8);

      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      checkOutput(0, F_MODE, 16'h0, "back to run");
      applyStimulus(0, 1, 0);
      checkOutput(0, F_AON, 16'h1, "arm alarm");

      setLive(4'd0, 4'd6, 4'd5, 4'd9);
      applyStimulus(0, 0, 1);
      checkOutput(0, F_BUZZ, 16'h0, "no buzz 06:59");
      setLive(4'd0, 4'd7, 4'd0, 4'd0);
      applyStimulus(0, 0, 1);
      checkOutput(0, F_BUZZ, 16'h1, "buzz at 07:00");
      applyStimulus(0, 0, 1);
      checkOutput(0, F_BUZZ, 16'h1, "ring tick1");
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 1);
      checkOutput(0, F_BUZZ, 16'h1, "ring tick2");
      applyStimulus(0, 0, 1);
      checkOutput(0, F_BUZZ, 16'h0, "ring tick3 silence");
      applyStimulus(0, 0, 1);
      checkOutput(0, F_BUZZ, 16'h0, "no retrigger a");
      applyStimulus(0, 0, 1);
      checkOutput(0, F_BUZZ, 16'h0, "no retrigger b");

      setLive(4'd0, 4'd7, 4'd0, 4'd1);
      applyStimulus(0, 0, 1);
      checkOutput(0, F_BUZZ, 16'h0, "no buzz 07:01");
      setLive(4'd0, 4'd6, 4'd5, 4'd9);
      applyStimulus(0, 0, 1);
      setLive(4'd0, 4'd7, 4'd0, 4'd0);
      applyStimulus(0, 0, 1);
      checkOutput(0, F_BUZZ, 16'h1, "rebuzz");
      applyStimulus(0, 1, 0);
      checkOutput(0, F_BUZZ, 16'h0, "inc silences");
      checkOutput(0, F_AON,  16'h1, "inc keeps armed");
      applyStimulus(0, 1, 0);
      checkOutput(0, F_AON,  16'h0, "inc disarms");
      applyStimulus(0, 1, 0);
      checkOutput(0, F_AON,  16'h1, "inc rearms");

      setLive(4'd0, 4'd6, 4'd5, 4'd9);
      applyStimulus(0, 0, 0);
      setLive(4'd0, 4'd7, 4'd0, 4'd0);
      applyStimulus(0, 0, 1);
      checkOutput(0, F_BUZZ, 16'h1, "buzz before leave");
      applyStimulus(1, 0, 0);
      checkOutput(0, F_BUZZ, 16'h0, "leave run silences");
      checkOutput(0, F_MODE, 16'h1, "leave run mode");

      // Reset mid-SET_AM with a modified alarm and the alarm armed.
      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 1, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 1, 0);
      checkOutput(0, F_ALARM, 16'h0801, "alarm before reset");
      checkOutput(0, F_MODE,  16'h4, "mode before reset");
      checkOutput(0, F_AON,   16'h1, "armed before reset");
      reset = 1'b1;
      applyStimulus(1, 1, 0);
      checkOutput(0, F_MODE,  16'h0, "reset overrides mode");
      checkOutput(0, F_ALARM, 16'h0700, "reset overrides inc");
      applyStimulus(0, 0, 0);
      checkResetState("midreset");
      reset = 1'b0;
      applyStimulus(1, 0, 0);
      checkOutput(0, F_MODE, 16'h1, "mode after reset");

      for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         nChecks++;
         nFails++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
      end
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
Front-panel controller for the wall clock timekeeper. It sequences the user modes (run, set hours, set minutes, set alarm hours, set alarm minutes) from debounced button pulses. It issues single-cycle increment commands to the timekeeper, holds the alarm time in BCD, and drives digit-blink masks to the seven-segment driver. It compares the live time against the alarm and sequences the buzzer.

Parameters:
BLINK_DIV, 50000000, CLK100MHZ cycles per blink half-period (0.5 s at 100 MHz); minimum 2
RING_SECS, 30, number of TickSec pulses the buzzer stays on before auto-silence
ALARM_H_RST, 8'h07, reset alarm hour as {tens,units} BCD
ALARM_M_RST, 8'h00, reset alarm minute as {tens,units} BCD

Ports:
CLK100MHZ  input  1  system clock; all logic on its rising edge
Reset  input  1  synchronous, active-high reset
ModePulse  input  1  one-cycle pulse, debounced mode button
IncPulse  input  1  one-cycle pulse, debounced increment button
TickSec  input  1  one-cycle pulse from timekeeper, once per second
hours2, hours1, mins2, mins1  input  4 each  live time, BCD tens/units
MinInc  output  1  one-cycle command: timekeeper adds one minute (no hour carry)
HourInc  output  1  one-cycle command: timekeeper adds one hour (23->00)
HoldSeconds  output  1  timekeeper freezes and zeroes its seconds counter while high
AlarmH2, AlarmH1, AlarmM2, AlarmM1  output  4 each  alarm time, BCD
DigitBlank  output  4  blank mask, bit3=hours2 … bit0=mins1
Mode  output  3  current state encoding
AlarmOn  output  1  alarm armed
Buzz  output  1  buzzer drive

Behaviour:
- Reset (sync) values: Mode=RUN, MinInc=HourInc=0, HoldSeconds=0, DigitBlank=0, AlarmOn=0, Buzz=0, Alarm digits = ALARM_H_RST/ALARM_M_RST, blink counter=0, ring counter=0, triggered latch=0. Reset overrides every other input in the same cycle.
- FSM encoding: RUN=0, SET_H=1, SET_M=2, SET_AH=3, SET_AM=4. Each ModePulse advances one state; SET_AM returns to RUN. Codes 5–7 are unreachable and recover to RUN on the next cycle.
- Simultaneous ModePulse and IncPulse: the mode change wins and the IncPulse is discarded.
- IncPulse in SET_H: HourInc high for exactly 1 cycle, on the cycle after the pulse. In SET_M, MinInc is asserted the same way. The controller never asserts both in one cycle.
- IncPulse in SET_AH: alarm hour +1 BCD, 09->10, 19->20, 23->00. In SET_AM: alarm minute +1 BCD, 59->00. Takes effect 1 cycle after the pulse. No carry between alarm hour and minute.
- IncPulse in RUN: if Buzz=1, it clears Buzz only and leaves AlarmOn unchanged. Otherwise it toggles AlarmOn.
- HoldSeconds = 1 exactly in SET_H and SET_M, registered from state.
- Blink: a free counter wraps at BLINK_DIV-1 and toggles the phase. Phase and counter reset on every state entry, so digits are visible first.
  - In the off-phase: SET_H/SET_AH blank 4'b1100; SET_M/SET_AM blank 4'b0011.
  - RUN: DigitBlank=0.
- The display source mux is external. The SS driver shows alarm digits when Mode is 3 or 4.
- Alarm match:
  - Condition: Mode=RUN, AlarmOn=1, TickSec=1, live {hours2,hours1,mins2,mins1} equals the alarm digits, and the triggered latch is 0.
  - On match: set Buzz, clear the ring counter, set the triggered latch.
  - The latch clears on the first cycle where live time differs from the alarm, so the alarm fires once per matching minute.
- Buzz clears on the RING_SECS-th TickSec after it was set. It also clears on IncPulse in RUN, on leaving RUN, on AlarmOn going 0, or on Reset.
- Live digits are sampled unregistered on TickSec. The timekeeper must update its digits on the same edge it pulses TickSec, or earlier.

Test Plan:
- Reset held 2 cycles mid-SET_AM with Buzz armed -> all outputs equal their reset values; alarm digits read 0,7,0,0.
- ModePulse x5 from RUN -> Mode steps 1,2,3,4,0. HoldSeconds is high only in Mode 1–2. Same-cycle ModePulse+IncPulse in SET_H -> Mode=2 and no HourInc.
- SET_AH with alarm 23:00, one IncPulse -> alarm 00:00. SET_AM with alarm 07:59, IncPulse -> 07:00. Each update lands 1 cycle after the pulse.
- BLINK_DIV=4, enter SET_M -> DigitBlank is 0000 for 4 cycles, then 0011 for 4 cycles, repeating. ModePulse to SET_AH -> the phase restarts visible.
- RUN, AlarmOn=1, alarm 07:00, live time stepping 06:59->07:00 with TickSec -> Buzz=1 on the first TickSec at 07:00. With RING_SECS=3 -> Buzz=0 after the 3rd following TickSec, and no retrigger during 07:00.
- Buzzing, IncPulse -> Buzz=0 and AlarmOn stays 1. Second IncPulse -> AlarmOn=0.
